// File: rtl/video_linebuf.sv
// Double-banked scanline buffer: renderer fills the back bank while the
// front bank is streamed out through a two-stage display pipeline.
module video_linebuf (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_line,
    input  logic       render_start,
    input  logic [4:0] backdrop,
    input  logic [7:0] hpos,
    input  logic       border,
    input  logic       blank,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [4:0] wr_data,
    input  logic       wr_done,
    input  logic       underrun_clr,
    output logic [4:0] pix_color,
    output logic       pix_blank,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WRITE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       front_sel;

    logic [4:0] bank0 [256];
    logic [4:0] bank1 [256];

    logic       we;
    logic [7:0] waddr;
    logic [4:0] wdata;

    logic [7:0] hpos_q;
    logic       border_q;
    logic       blank_q;
    logic       sel_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        we       = 1'b0;
        waddr    = cnt;
        wdata    = backdrop;
        wr_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (render_start) begin
                    state_nx = CLEAR;
                    cnt_nx   = 8'd0;
                end
            end
            CLEAR: begin
                we     = 1'b1;
                cnt_nx = cnt + 8'd1;
                if (cnt == 8'd255)
                    state_nx = WRITE;
            end
            WRITE: begin
                wr_ready = 1'b1;
                we       = wr_valid;
                waddr    = wr_x;
                wdata    = wr_data;
                if (wr_done)
                    state_nx = DONE;
            end
            DONE: begin
            end
        endcase
        // Line swap always wins: the build is abandoned for this line.
        if (next_line)
            state_nx = IDLE;
        if (reset)
            we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            front_sel <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (next_line)
                front_sel <= ~front_sel;
            if (next_line && state == CLEAR)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

    // Writes always land in the back bank (the one not selected as front).
    always_ff @(posedge clk) begin
        if (we) begin
            if (front_sel)
                bank0[waddr] <= wdata;
            else
                bank1[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q    <= 8'd0;
            border_q  <= 1'b0;
            blank_q   <= 1'b1;
            sel_q     <= 1'b0;
            pix_color <= 5'd0;
            pix_blank <= 1'b1;
        end else begin
            hpos_q    <= hpos;
            border_q  <= border;
            blank_q   <= blank;
            sel_q     <= front_sel;
            pix_blank <= blank_q;
            if (blank_q)
                pix_color <= 5'd0;
            else if (border_q)
                pix_color <= backdrop;
            else if (sel_q)
                pix_color <= bank1[hpos_q];
            else
                pix_color <= bank0[hpos_q];
        end
    end

endmodule

// File: tb/tb_video_linebuf.sv
// Directed-vector bench for the double-banked scanline buffer.
module tb_video_linebuf;

    logic       clk = 1'b0;
    logic       reset;
    logic       next_line;
    logic       render_start;
    logic [4:0] backdrop;
    logic [7:0] hpos;
    logic       border;
    logic       blank;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [4:0] wr_data;
    logic       wr_done;
    logic       underrun_clr;
    logic [4:0] pix_color;
    logic       pix_blank;
    logic       underrun;

    int n_vec = 0;
    int n_err = 0;

    video_linebuf dut (
        .clk          (clk),
        .reset        (reset),
        .next_line    (next_line),
        .render_start (render_start),
        .backdrop     (backdrop),
        .hpos         (hpos),
        .border       (border),
        .blank        (blank),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .underrun_clr (underrun_clr),
        .pix_color    (pix_color),
        .pix_blank    (pix_blank),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        render_start = 1'b1;
        tick();
        render_start = 1'b0;
    endtask

    task automatic pulse_line();
        next_line = 1'b1;
        tick();
        next_line = 1'b0;
    endtask

    task automatic show(input logic [7:0] h);
        hpos = h;
        tick(2);
    endtask

    task automatic wr(input logic [7:0] x, input logic [4:0] d,
                      input logic done);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_data  = d;
        wr_done  = done;
        tick();
        wr_valid = 1'b0;
        wr_done  = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        next_line    = 1'b0;
        render_start = 1'b0;
        backdrop     = 5'h0A;
        hpos         = 8'd0;
        border       = 1'b0;
        blank        = 1'b0;
        wr_valid     = 1'b0;
        wr_x         = 8'd0;
        wr_data      = 5'd0;
        wr_done      = 1'b0;
        underrun_clr = 1'b0;
        tick(2);
        chk("rst_ready", {7'd0, wr_ready}, 8'd0);
        chk("rst_color", {3'd0, pix_color}, 8'd0);
        chk("rst_blank", {7'd0, pix_blank}, 8'd1);
        chk("rst_underrun", {7'd0, underrun}, 8'd0);
        reset = 1'b0;
        tick();

        // Clear back bank to 0x0A; a write during CLEAR must be ignored.
        pulse_start();
        chk("clear_ready", {7'd0, wr_ready}, 8'd0);
        wr_valid = 1'b1;
        wr_x     = 8'd20;
        wr_data  = 5'd1;
        tick(255);
        wr_valid = 1'b0;
        chk("clear_not_done", {7'd0, wr_ready}, 8'd0);
        tick();
        chk("write_ready", {7'd0, wr_ready}, 8'd1);
        pulse_line();
        chk("swap_idle", {7'd0, wr_ready}, 8'd0);
        begin
            int bad = 0;
            for (int h = 0; h < 256; h++) begin
                show(8'(h));
                if (pix_color !== 5'h0A) begin
                    bad++;
                    $display("FAIL sweep col %0d: got %0h expected 0a",
                             h, pix_color);
                end
            end
            n_vec += 256;
            n_err += bad;
        end

        // Pixel writes incl. overwrite, then a write during DONE.
        pulse_start();
        tick(256);
        chk("write_ready2", {7'd0, wr_ready}, 8'd1);
        wr(8'd0, 5'd3, 1'b0);
        wr(8'd255, 5'd31, 1'b0);
        wr(8'd10, 5'd7, 1'b0);
        wr(8'd10, 5'd9, 1'b1);
        chk("done_ready", {7'd0, wr_ready}, 8'd0);
        wr(8'd5, 5'd17, 1'b0);
        pulse_line();
        show(8'd0);
        chk("col0", {3'd0, pix_color}, 8'd3);
        show(8'd255);
        chk("col255", {3'd0, pix_color}, 8'd31);
        show(8'd10);
        chk("col10", {3'd0, pix_color}, 8'd9);
        show(8'd5);
        chk("col5_done_ignored", {3'd0, pix_color}, 8'h0A);
        show(8'd100);
        chk("col100", {3'd0, pix_color}, 8'h0A);
        chk("pix_blank_lo", {7'd0, pix_blank}, 8'd0);

        // Blank and border overrides.
        blank = 1'b1;
        show(8'd0);
        chk("blank_color", {3'd0, pix_color}, 8'd0);
        chk("blank_flag", {7'd0, pix_blank}, 8'd1);
        blank    = 1'b0;
        border   = 1'b1;
        backdrop = 5'h15;
        show(8'd0);
        chk("border_c0", {3'd0, pix_color}, 8'h15);
        show(8'd10);
        chk("border_c10", {3'd0, pix_color}, 8'h15);
        border = 1'b0;

        // Swap mid-clear: partial clear with 0x11 over old 0x0A contents.
        backdrop = 5'h11;
        pulse_start();
        tick(100);
        pulse_line();
        chk("underrun_set", {7'd0, underrun}, 8'd1);
        chk("abort_idle", {7'd0, wr_ready}, 8'd0);
        show(8'd99);
        chk("partial_col99", {3'd0, pix_color}, 8'h11);
        show(8'd150);
        chk("partial_col150", {3'd0, pix_color}, 8'h0A);
        chk("underrun_sticky", {7'd0, underrun}, 8'd1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("underrun_clr", {7'd0, underrun}, 8'd0);

        // Set wins over simultaneous clear.
        pulse_start();
        next_line    = 1'b1;
        underrun_clr = 1'b1;
        tick();
        next_line    = 1'b0;
        underrun_clr = 1'b0;
        chk("set_wins", {7'd0, underrun}, 8'd1);

        // next_line beats render_start: FSM stays IDLE.
        next_line    = 1'b1;
        render_start = 1'b1;
        tick();
        next_line    = 1'b0;
        render_start = 1'b0;
        tick(260);
        chk("line_beats_start", {7'd0, wr_ready}, 8'd0);

        // Reset while in WRITE.
        pulse_start();
        tick(256);
        chk("pre_reset_ready", {7'd0, wr_ready}, 8'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready", {7'd0, wr_ready}, 8'd0);
        chk("mid_rst_underrun", {7'd0, underrun}, 8'd0);
        chk("mid_rst_blank", {7'd0, pix_blank}, 8'd1);
        reset    = 1'b0;
        wr_valid = 1'b1;
        tick(3);
        wr_valid = 1'b0;
        chk("post_rst_ready", {7'd0, wr_ready}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
